// File: rtl/pc_ctrl_pkg.sv
// pc_ctrl_pkg: shared PC bus constants, pause levels and sequencer state encodings
package pc_ctrl_pkg;
  localparam int          PC_BUS_W      = 16;
  localparam logic [15:0] RESET_PC      = 16'h0000;
  localparam logic        PAUSE_ENABLE  = 1'b1;
  localparam logic        PAUSE_DISABLE = 1'b0;
  localparam logic [15:0] NOP_INSTR     = 16'h0000;
  typedef enum logic {
    S_RUN  = 1'b0,
    S_HOLD = 1'b1
  } pc_state_t;
endpackage

// File: rtl/pc_ctrl_sat_counter.sv
// sat_counter: counts cycles with inc high and sticks at all-ones
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_50Mhz,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);
  always_ff @(posedge clk_50Mhz or negedge rst)
    if (!rst) cnt <= '0;
    else if (inc && !(&cnt)) cnt <= cnt + 1'b1;
endmodule

// File: rtl/pc_ctrl.sv
// pc_ctrl: next-PC select plus pipeline pause/flush/bubble control
// with a hold state that keeps a redirect alive across instruction-RAM conflicts.
module pc_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int             PC_W     = 16,
  parameter logic [PC_W-1:0] FIRST_PC = RESET_PC,
  parameter int             CNT_W    = 16
) (
  input  logic             clk_50Mhz,
  input  logic             rst,
  input  logic [PC_W-1:0]  PC_cur,
  input  logic             jump_req,
  input  logic [PC_W-1:0]  jump_target,
  input  logic             branch_req,
  input  logic [PC_W-1:0]  branch_target,
  input  logic             load_use,
  input  logic             mem_conflict,
  output logic [PC_W-1:0]  PC_next,
  output logic             PC_pause,
  output logic             IF_ID_pause,
  output logic             IF_ID_flush,
  output logic             ID_EX_bubble,
  output logic             redir_pending,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  pc_state_t       r_state;
  logic [PC_W-1:0] r_pend_target;
  logic            w_redir;
  logic            w_hold;
  logic            w_lu;
  logic [PC_W-1:0] w_target;
  logic [PC_W-1:0] w_seq;
  assign w_redir  = jump_req | branch_req;
  assign w_target = jump_req ? jump_target : branch_target;
  assign w_seq    = PC_cur + 1'b1;
  assign w_hold   = (r_state == S_HOLD);
  // load_use only matters in RUN with no redirect; it then beats the conflict flush
  assign w_lu     = !w_hold && !w_redir && load_use;
  always_comb begin
    PC_next       = w_hold ? r_pend_target :
                    (w_redir && !mem_conflict) ? w_target :
                    (w_redir || mem_conflict || load_use) ? PC_cur : w_seq;
    PC_pause      = (mem_conflict || w_lu) ? PAUSE_ENABLE : PAUSE_DISABLE;
    IF_ID_pause   = w_lu;
    ID_EX_bubble  = w_lu;
    IF_ID_flush   = w_hold || (!w_lu && (w_redir || mem_conflict));
    redir_pending = w_hold;
  end
  always_ff @(posedge clk_50Mhz or negedge rst)
    if (!rst) begin
      r_state       <= S_RUN;
      r_pend_target <= FIRST_PC;
    end else if (w_hold) begin
      if (!mem_conflict) r_state <= S_RUN;
    end else if (w_redir && mem_conflict) begin
      r_state       <= S_HOLD;
      r_pend_target <= w_target;
    end
  sat_counter #(.CNT_W(CNT_W)) u_stall (
    .clk_50Mhz(clk_50Mhz), .rst(rst), .inc(PC_pause == PAUSE_ENABLE), .cnt(stall_cnt)
  );
  sat_counter #(.CNT_W(CNT_W)) u_flush (
    .clk_50Mhz(clk_50Mhz), .rst(rst), .inc(IF_ID_flush), .cnt(flush_cnt)
  );
endmodule

// File: tb/tb_pc_ctrl.sv
// tb_pc_ctrl: directed checks of pc_ctrl redirect, stall, hold, reset and saturation
module tb_pc_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pc_cur, jt, bt;
  logic        jr, br, lu, mc;
  logic [15:0] pc_next;
  logic        pc_pause, ifid_pause, ifid_flush, idex_bubble, pending;
  logic [3:0]  stall_cnt, flush_cnt;
  int total = 0;
  int bad   = 0;
  pc_ctrl #(.PC_W(16), .FIRST_PC(16'h0000), .CNT_W(4)) dut (
    .clk_50Mhz(clk), .rst(rst), .PC_cur(pc_cur),
    .jump_req(jr), .jump_target(jt), .branch_req(br), .branch_target(bt),
    .load_use(lu), .mem_conflict(mc),
    .PC_next(pc_next), .PC_pause(pc_pause), .IF_ID_pause(ifid_pause),
    .IF_ID_flush(ifid_flush), .ID_EX_bubble(idex_bubble), .redir_pending(pending),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    #1;
  endtask
  initial begin
    rst = 1'b0; pc_cur = 16'h0000; jt = 16'h0000; bt = 16'h0000;
    jr = 1'b0; br = 1'b0; lu = 1'b0; mc = 1'b0;
    #12 rst = 1'b1;
    tick();
    pc_cur = 16'h0010; #1;
    chk("seq_next", pc_next, 16'h0011);
    chk("seq_pause", {15'b0, pc_pause}, 16'h0);
    chk("seq_ifid_pause", {15'b0, ifid_pause}, 16'h0);
    chk("seq_flush", {15'b0, ifid_flush}, 16'h0);
    chk("seq_bubble", {15'b0, idex_bubble}, 16'h0);
    chk("seq_pending", {15'b0, pending}, 16'h0);
    chk("rst_stall_cnt", {12'b0, stall_cnt}, 16'h0);
    chk("rst_flush_cnt", {12'b0, flush_cnt}, 16'h0);
    pc_cur = 16'hFFFF; #1;
    chk("wrap_next", pc_next, 16'h0000);
    pc_cur = 16'h0010; br = 1'b1; bt = 16'h0040; jr = 1'b1; jt = 16'h0080; #1;
    chk("jprio_next", pc_next, 16'h0080);
    chk("jprio_flush", {15'b0, ifid_flush}, 16'h1);
    chk("jprio_pause", {15'b0, pc_pause}, 16'h0);
    tick();
    br = 1'b0; jr = 1'b0; #1;
    chk("jprio_flush_cnt", {12'b0, flush_cnt}, 16'h1);
    chk("jprio_stall_cnt", {12'b0, stall_cnt}, 16'h0);
    chk("jprio_stay_run", {15'b0, pending}, 16'h0);
    br = 1'b1; bt = 16'h0044; #1;
    chk("br_only_next", pc_next, 16'h0044);
    br = 1'b0;
    pc_cur = 16'h0020; lu = 1'b1; #1;
    chk("lu_next", pc_next, 16'h0020);
    chk("lu_pause", {15'b0, pc_pause}, 16'h1);
    chk("lu_ifid_pause", {15'b0, ifid_pause}, 16'h1);
    chk("lu_bubble", {15'b0, idex_bubble}, 16'h1);
    chk("lu_flush", {15'b0, ifid_flush}, 16'h0);
    tick();
    lu = 1'b0; #1;
    chk("lu_stall_cnt", {12'b0, stall_cnt}, 16'h1);
    chk("lu_flush_cnt", {12'b0, flush_cnt}, 16'h1);
    lu = 1'b1; mc = 1'b1; #1;
    chk("lumc_flush", {15'b0, ifid_flush}, 16'h0);
    chk("lumc_ifid_pause", {15'b0, ifid_pause}, 16'h1);
    chk("lumc_bubble", {15'b0, idex_bubble}, 16'h1);
    chk("lumc_pause", {15'b0, pc_pause}, 16'h1);
    lu = 1'b0; #1;
    chk("mc_next", pc_next, 16'h0020);
    chk("mc_pause", {15'b0, pc_pause}, 16'h1);
    chk("mc_flush", {15'b0, ifid_flush}, 16'h1);
    chk("mc_bubble", {15'b0, idex_bubble}, 16'h0);
    lu = 1'b1; jr = 1'b1; jt = 16'h0055; mc = 1'b0; #1;
    chk("redir_beats_lu_next", pc_next, 16'h0055);
    chk("redir_beats_lu_pause", {15'b0, pc_pause}, 16'h0);
    chk("redir_beats_lu_bubble", {15'b0, idex_bubble}, 16'h0);
    lu = 1'b0; jr = 1'b0;
    do_reset();
    pc_cur = 16'h0030; br = 1'b1; bt = 16'h0100; mc = 1'b1; #1;
    chk("hold_c1_pause", {15'b0, pc_pause}, 16'h1);
    chk("hold_c1_flush", {15'b0, ifid_flush}, 16'h1);
    chk("hold_c1_pending", {15'b0, pending}, 16'h0);
    tick();
    br = 1'b0; jr = 1'b1; jt = 16'h0200; #1;
    chk("hold_c2_pending", {15'b0, pending}, 16'h1);
    chk("hold_c2_next", pc_next, 16'h0100);
    chk("hold_c2_pause", {15'b0, pc_pause}, 16'h1);
    chk("hold_c2_flush", {15'b0, ifid_flush}, 16'h1);
    tick();
    jr = 1'b0; #1;
    chk("hold_c3_pending", {15'b0, pending}, 16'h1);
    chk("hold_c3_next", pc_next, 16'h0100);
    tick();
    mc = 1'b0; lu = 1'b1; #1;
    chk("hold_c4_pending", {15'b0, pending}, 16'h1);
    chk("hold_c4_next", pc_next, 16'h0100);
    chk("hold_c4_pause", {15'b0, pc_pause}, 16'h0);
    chk("hold_c4_flush", {15'b0, ifid_flush}, 16'h1);
    chk("hold_c4_bubble", {15'b0, idex_bubble}, 16'h0);
    tick();
    lu = 1'b0; #1;
    chk("hold_exit_pending", {15'b0, pending}, 16'h0);
    chk("hold_exit_next", pc_next, 16'h0031);
    chk("hold_stall_cnt", {12'b0, stall_cnt}, 16'h3);
    chk("hold_flush_cnt", {12'b0, flush_cnt}, 16'h4);
    br = 1'b1; bt = 16'h0300; mc = 1'b1;
    tick();
    br = 1'b0; #1;
    chk("rstmid_pending_before", {15'b0, pending}, 16'h1);
    rst = 1'b0; #1;
    chk("rstmid_pending", {15'b0, pending}, 16'h0);
    chk("rstmid_stall_cnt", {12'b0, stall_cnt}, 16'h0);
    chk("rstmid_flush_cnt", {12'b0, flush_cnt}, 16'h0);
    mc = 1'b0;
    tick();
    rst = 1'b1; #1;
    chk("rstmid_after_next", pc_next, 16'h0031);
    tick();
    chk("rstmid_after_pending", {15'b0, pending}, 16'h0);
    chk("rstmid_after_stall", {12'b0, stall_cnt}, 16'h0);
    mc = 1'b1;
    repeat (17) tick();
    chk("sat_stall_cnt", {12'b0, stall_cnt}, 16'h000F);
    chk("sat_flush_cnt", {12'b0, flush_cnt}, 16'h000F);
    mc = 1'b0;
    tick();
    chk("sat_hold_stall", {12'b0, stall_cnt}, 16'h000F);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
